// File: rtl/axi_mem_slave_pkg.sv
// ============================================================================
// Module : axi_mem_slave_pkg
// Brief  : Shared response codes, FSM encodings and defaults for the memory slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_mem_slave_pkg;

    localparam int AXI_WIDTH_DA = 32;
    localparam int AXI_WIDTH_DS = AXI_WIDTH_DA / 8;

    localparam logic [31:0] DEFAULT_MEM_BASE_ADDR = 32'h8000_0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_mem_slave_if.sv
// ============================================================================
// Module : axi_mem_slave_if
// Brief  : AXI-style burst bus (AW/W/B/AR/R channels) with master/slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi_mem_slave_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_ID = 4
);
    import axi_mem_slave_pkg::*;

    logic                      S_AWVALID;
    logic                      S_AWREADY;
    logic [AXI_WIDTH_AD-1:0]   S_AWADDR;
    logic [AXI_WIDTH_ID-1:0]   S_AWID;
    logic [7:0]                S_AWLEN;
    logic                      S_WVALID;
    logic                      S_WREADY;
    logic [AXI_WIDTH_DA-1:0]   S_WDATA;
    logic [AXI_WIDTH_DS-1:0]   S_WSTRB;
    logic                      S_WLAST;
    logic                      S_BVALID;
    logic                      S_BREADY;
    logic [1:0]                S_BRESP;
    logic [AXI_WIDTH_ID-1:0]   S_BID;
    logic                      S_ARVALID;
    logic                      S_ARREADY;
    logic [AXI_WIDTH_AD-1:0]   S_ARADDR;
    logic [AXI_WIDTH_ID-1:0]   S_ARID;
    logic [7:0]                S_ARLEN;
    logic                      S_RVALID;
    logic                      S_RREADY;
    logic [AXI_WIDTH_DA-1:0]   S_RDATA;
    logic                      S_RLAST;
    logic [AXI_WIDTH_ID-1:0]   S_RID;
    logic [1:0]                S_RRESP;

    modport slave (
        input  S_AWVALID, S_AWADDR, S_AWID, S_AWLEN,
        output S_AWREADY,
        input  S_WVALID, S_WDATA, S_WSTRB, S_WLAST,
        output S_WREADY,
        output S_BVALID, S_BRESP, S_BID,
        input  S_BREADY,
        input  S_ARVALID, S_ARADDR, S_ARID, S_ARLEN,
        output S_ARREADY,
        output S_RVALID, S_RDATA, S_RLAST, S_RID, S_RRESP,
        input  S_RREADY
    );

    modport master (
        output S_AWVALID, S_AWADDR, S_AWID, S_AWLEN,
        input  S_AWREADY,
        output S_WVALID, S_WDATA, S_WSTRB, S_WLAST,
        input  S_WREADY,
        input  S_BVALID, S_BRESP, S_BID,
        output S_BREADY,
        output S_ARVALID, S_ARADDR, S_ARID, S_ARLEN,
        input  S_ARREADY,
        input  S_RVALID, S_RDATA, S_RLAST, S_RID, S_RRESP,
        output S_RREADY
    );

endinterface

`default_nettype wire

// File: rtl/axi_mem_slave_ram.sv
// ============================================================================
// Module : axi_mem_slave_ram
// Brief  : Word array with one byte-enabled write port and one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_mem_slave_ram #(
    parameter int MEM_DEPTH = 65536,
    parameter int MEM_AW    = 16,
    parameter int DATA_W    = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MEM_AW-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [MEM_AW-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Non-blocking read and write in one process gives read-first on a collision.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_mem_slave.sv
// ============================================================================
// Module : axi_mem_slave
// Brief  : INCR-burst memory slave with independent read and write engines.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int                      AXI_WIDTH_AD  = 32,
    parameter int                      AXI_WIDTH_ID  = 4,
    parameter logic [AXI_WIDTH_AD-1:0] MEM_BASE_ADDR = AXI_WIDTH_AD'(DEFAULT_MEM_BASE_ADDR),
    parameter int                      MEM_DEPTH     = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_mem_slave_if.slave       s
);

    localparam int                      MEM_AW   = $clog2(MEM_DEPTH);
    localparam logic [AXI_WIDTH_AD-1:0] DEPTH_AD = AXI_WIDTH_AD'(MEM_DEPTH);
    localparam logic [AXI_WIDTH_AD-1:0] AD_ONE   = AXI_WIDTH_AD'(1);

    function automatic logic [AXI_WIDTH_AD-1:0] word_index(input logic [AXI_WIDTH_AD-1:0] addr);
        logic [AXI_WIDTH_AD-1:0] off;
        off = addr - MEM_BASE_ADDR;
        return off >> 2;
    endfunction

    // Addresses below the base are flagged separately since the subtraction wraps.
    function automatic logic in_window(input logic [AXI_WIDTH_AD-1:0] idx, input logic below);
        return !below && (idx < DEPTH_AD);
    endfunction

    logic                    ram_we, ram_re;
    logic [MEM_AW-1:0]       ram_waddr, ram_raddr;
    logic [AXI_WIDTH_DA-1:0] ram_rdata;

    wr_state_t               wr_state, wr_state_nxt;
    logic                    awready, awready_nxt, wready, wready_nxt, bvalid, bvalid_nxt;
    logic [1:0]              bresp, bresp_nxt;
    logic [AXI_WIDTH_ID-1:0] bid, bid_nxt;
    logic [7:0]              wr_len, wr_len_nxt, wr_beat, wr_beat_nxt;
    logic [AXI_WIDTH_AD-1:0] wr_idx, wr_idx_nxt;
    logic                    wr_below, wr_below_nxt, wr_err, wr_err_nxt;
    logic                    w_last_beat, w_beat_err, w_beat_ok;

    rd_state_t               rd_state, rd_state_nxt;
    logic                    arready, arready_nxt, rvalid, rvalid_nxt, rlast, rlast_nxt;
    logic [1:0]              rresp, rresp_nxt;
    logic [AXI_WIDTH_ID-1:0] rid, rid_nxt;
    logic [7:0]              rd_len, rd_len_nxt, rd_beat, rd_beat_nxt;
    logic [AXI_WIDTH_AD-1:0] rd_idx, rd_idx_nxt, rd_issue_idx;
    logic                    rd_below, rd_below_nxt, rd_issue_below, rd_oor, rd_oor_nxt;

    axi_mem_slave_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_AW    (MEM_AW),
        .DATA_W    (AXI_WIDTH_DA)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wstrb (s.S_WSTRB),
        .wdata (s.S_WDATA),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            bid      <= '0;
            wr_len   <= '0;
            wr_beat  <= '0;
            wr_idx   <= '0;
            wr_below <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            awready  <= awready_nxt;
            wready   <= wready_nxt;
            bvalid   <= bvalid_nxt;
            bresp    <= bresp_nxt;
            bid      <= bid_nxt;
            wr_len   <= wr_len_nxt;
            wr_beat  <= wr_beat_nxt;
            wr_idx   <= wr_idx_nxt;
            wr_below <= wr_below_nxt;
            wr_err   <= wr_err_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        awready_nxt  = awready;
        wready_nxt   = wready;
        bvalid_nxt   = bvalid;
        bresp_nxt    = bresp;
        bid_nxt      = bid;
        wr_len_nxt   = wr_len;
        wr_beat_nxt  = wr_beat;
        wr_idx_nxt   = wr_idx;
        wr_below_nxt = wr_below;
        wr_err_nxt   = wr_err;
        w_last_beat  = (wr_beat == wr_len);
        w_beat_ok    = in_window(wr_idx, wr_below);
        w_beat_err   = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = wr_idx[MEM_AW-1:0];
        case (wr_state)
            W_IDLE: begin
                awready_nxt = 1'b1;
                if (awready && s.S_AWVALID) begin
                    wr_state_nxt = W_DATA;
                    awready_nxt  = 1'b0;
                    wready_nxt   = 1'b1;
                    bid_nxt      = s.S_AWID;
                    wr_len_nxt   = s.S_AWLEN;
                    wr_beat_nxt  = '0;
                    wr_idx_nxt   = word_index(s.S_AWADDR);
                    wr_below_nxt = (s.S_AWADDR < MEM_BASE_ADDR);
                    wr_err_nxt   = 1'b0;
                end
            end
            W_DATA: begin
                if (wready && s.S_WVALID) begin
                    ram_we     = w_beat_ok;
                    w_beat_err = !w_beat_ok || (s.S_WLAST != w_last_beat);
                    if (w_last_beat) begin
                        wr_state_nxt = W_RESP;
                        wready_nxt   = 1'b0;
                        bvalid_nxt   = 1'b1;
                        bresp_nxt    = resp_code(wr_err || w_beat_err);
                    end else begin
                        wr_beat_nxt = wr_beat + 8'd1;
                        wr_idx_nxt  = wr_idx + AD_ONE;
                        wr_err_nxt  = wr_err || w_beat_err;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && s.S_BREADY) begin
                    wr_state_nxt = W_IDLE;
                    bvalid_nxt   = 1'b0;
                    awready_nxt  = 1'b1;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= RESP_OKAY;
            rid      <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_idx   <= '0;
            rd_below <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            arready  <= arready_nxt;
            rvalid   <= rvalid_nxt;
            rlast    <= rlast_nxt;
            rresp    <= rresp_nxt;
            rid      <= rid_nxt;
            rd_len   <= rd_len_nxt;
            rd_beat  <= rd_beat_nxt;
            rd_idx   <= rd_idx_nxt;
            rd_below <= rd_below_nxt;
            rd_oor   <= rd_oor_nxt;
        end
    end

    // The RAM is read only when a beat is launched, so its output holds across stalls.
    always_comb begin
        rd_state_nxt   = rd_state;
        arready_nxt    = arready;
        rvalid_nxt     = rvalid;
        rlast_nxt      = rlast;
        rresp_nxt      = rresp;
        rid_nxt        = rid;
        rd_len_nxt     = rd_len;
        rd_beat_nxt    = rd_beat;
        rd_idx_nxt     = rd_idx;
        rd_below_nxt   = rd_below;
        rd_oor_nxt     = rd_oor;
        rd_issue_idx   = rd_idx + AD_ONE;
        rd_issue_below = rd_below;
        ram_re         = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready_nxt = 1'b1;
                if (arready && s.S_ARVALID) begin
                    rd_issue_idx   = word_index(s.S_ARADDR);
                    rd_issue_below = (s.S_ARADDR < MEM_BASE_ADDR);
                    ram_re         = in_window(rd_issue_idx, rd_issue_below);
                    rd_state_nxt   = R_DATA;
                    arready_nxt    = 1'b0;
                    rvalid_nxt     = 1'b1;
                    rid_nxt        = s.S_ARID;
                    rd_len_nxt     = s.S_ARLEN;
                    rd_beat_nxt    = '0;
                    rd_idx_nxt     = rd_issue_idx;
                    rd_below_nxt   = rd_issue_below;
                    rlast_nxt      = (s.S_ARLEN == 8'd0);
                    rd_oor_nxt     = !ram_re;
                    rresp_nxt      = resp_code(!ram_re);
                end
            end
            R_DATA: begin
                if (rvalid && s.S_RREADY) begin
                    if (rlast) begin
                        rd_state_nxt = R_IDLE;
                        rvalid_nxt   = 1'b0;
                        rlast_nxt    = 1'b0;
                        arready_nxt  = 1'b1;
                    end else begin
                        ram_re      = in_window(rd_issue_idx, rd_issue_below);
                        rd_idx_nxt  = rd_issue_idx;
                        rd_beat_nxt = rd_beat + 8'd1;
                        rlast_nxt   = ((rd_beat + 8'd1) == rd_len);
                        rd_oor_nxt  = !ram_re;
                        rresp_nxt   = resp_code(!ram_re);
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
        ram_raddr = rd_issue_idx[MEM_AW-1:0];
    end

    assign s.S_AWREADY = awready;
    assign s.S_WREADY  = wready;
    assign s.S_BVALID  = bvalid;
    assign s.S_BRESP   = bresp;
    assign s.S_BID     = bid;
    assign s.S_ARREADY = arready;
    assign s.S_RVALID  = rvalid;
    assign s.S_RLAST   = rlast;
    assign s.S_RRESP   = rresp;
    assign s.S_RID     = rid;
    assign s.S_RDATA   = (rvalid && !rd_oor) ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
// ============================================================================
// Module : tb_axi_mem_slave
// Brief  : Directed self-checking bench for the burst memory slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_mem_slave;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          DEPTH     = 65536;
    localparam logic [31:0] EDGE_ADDR = 32'h8003_FFF8;
    localparam int          TMO       = 200;
    localparam int          TMO_LONG  = 5000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   stable_err;

    logic [31:0] wbuf      [256];
    logic [31:0] rbuf      [256];
    logic [1:0]  rresp_buf [256];
    logic        rlast_buf [256];

    axi_mem_slave_if #(.AXI_WIDTH_AD(32), .AXI_WIDTH_ID(4)) bus ();

    axi_mem_slave #(
        .AXI_WIDTH_AD  (32),
        .AXI_WIDTH_ID  (4),
        .MEM_BASE_ADDR (BASE),
        .MEM_DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [3:0] strb, input bit bad_last, input bit bp,
                             output logic [1:0] resp, output logic [3:0] bid_o);
        int t;
        bit done;
        @(negedge clk);
        bus.S_AWVALID = 1'b1;
        bus.S_AWADDR  = addr;
        bus.S_AWID    = id;
        bus.S_AWLEN   = len;
        t = 0;
        while (bus.S_AWREADY !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check_value("aw_timeout", 1, 0);
        @(negedge clk);
        bus.S_AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.S_WVALID = 1'b1;
            bus.S_WDATA  = wbuf[b];
            bus.S_WSTRB  = strb;
            bus.S_WLAST  = (b == int'(len)) ^ bad_last;
            t = 0;
            while (bus.S_WREADY !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) check_value("w_timeout", 1, 0);
            @(negedge clk);
        end
        bus.S_WVALID = 1'b0;
        bus.S_WLAST  = 1'b0;
        done  = 1'b0;
        resp  = 2'b11;
        bid_o = 4'hx;
        t = 0;
        while (!done && t < TMO) begin
            bus.S_BREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.S_BVALID && bus.S_BREADY) begin
                resp  = bus.S_BRESP;
                bid_o = bus.S_BID;
                done  = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        bus.S_BREADY = 1'b0;
        if (!done) check_value("b_timeout", 1, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input bit bp, input string tag, output int nbeats);
        int   t;
        bit   stalled;
        logic [31:0] held_d;
        logic [1:0]  held_r;
        logic        held_l;
        nbeats  = 0;
        stalled = 1'b0;
        held_d  = '0;
        held_r  = '0;
        held_l  = 1'b0;
        @(negedge clk);
        bus.S_ARVALID = 1'b1;
        bus.S_ARADDR  = addr;
        bus.S_ARID    = id;
        bus.S_ARLEN   = len;
        t = 0;
        while (bus.S_ARREADY !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check_value({tag, "_ar_timeout"}, 1, 0);
        @(negedge clk);
        bus.S_ARVALID = 1'b0;
        check_value({tag, "_rvalid_lat"}, 32'(bus.S_RVALID), 1);
        check_value({tag, "_rid"}, 32'(bus.S_RID), 32'(id));
        t = 0;
        while (nbeats <= int'(len) && t < TMO_LONG) begin
            if (stalled && bus.S_RVALID &&
                (bus.S_RDATA !== held_d || bus.S_RRESP !== held_r || bus.S_RLAST !== held_l))
                stable_err++;
            bus.S_RREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.S_RVALID && bus.S_RREADY) begin
                rbuf[nbeats]      = bus.S_RDATA;
                rresp_buf[nbeats] = bus.S_RRESP;
                rlast_buf[nbeats] = bus.S_RLAST;
                nbeats++;
                stalled = 1'b0;
            end else if (bus.S_RVALID) begin
                stalled = 1'b1;
                held_d  = bus.S_RDATA;
                held_r  = bus.S_RRESP;
                held_l  = bus.S_RLAST;
            end
            @(negedge clk);
            t++;
        end
        bus.S_RREADY = 1'b0;
        check_value({tag, "_nbeats"}, 32'(nbeats), 32'(int'(len) + 1));
    endtask

    logic [1:0]  resp;
    logic [3:0]  bidv;
    int          n;

    initial begin
        checks     = 0;
        failures   = 0;
        stable_err = 0;
        rst = 1'b1;
        bus.S_AWVALID = 1'b0; bus.S_AWADDR = '0; bus.S_AWID = '0; bus.S_AWLEN = '0;
        bus.S_WVALID  = 1'b0; bus.S_WDATA  = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0;
        bus.S_BREADY  = 1'b0;
        bus.S_ARVALID = 1'b0; bus.S_ARADDR = '0; bus.S_ARID = '0; bus.S_ARLEN = '0;
        bus.S_RREADY  = 1'b0;

        // Reset values, then readies rise the first cycle after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_awready", 32'(bus.S_AWREADY), 0);
        check_value("rst_arready", 32'(bus.S_ARREADY), 0);
        check_value("rst_wready",  32'(bus.S_WREADY), 0);
        check_value("rst_bvalid",  32'(bus.S_BVALID), 0);
        check_value("rst_rvalid",  32'(bus.S_RVALID), 0);
        check_value("rst_rdata",   bus.S_RDATA, 0);
        check_value("rst_bid",     32'(bus.S_BID), 0);
        rst = 1'b0;
        @(negedge clk);
        check_value("post_rst_awready", 32'(bus.S_AWREADY), 1);
        check_value("post_rst_arready", 32'(bus.S_ARREADY), 1);

        // 16-beat write then read-back at the window base.
        for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
        axi_write(BASE, 4'h5, 8'd15, 4'hF, 1'b0, 1'b0, resp, bidv);
        check_value("t1_bresp", 32'(resp), 0);
        check_value("t1_bid", 32'(bidv), 5);
        axi_read(BASE, 4'hA, 8'd15, 1'b0, "t1", n);
        for (int i = 0; i < 16; i++) begin
            check_value($sformatf("t1_data[%0d]", i), rbuf[i], 32'(i));
            check_value($sformatf("t1_rresp[%0d]", i), 32'(rresp_buf[i]), 0);
            check_value($sformatf("t1_rlast[%0d]", i), 32'(rlast_buf[i]), 32'(i == 15));
        end

        // Byte strobes merge into an existing word.
        wbuf[0] = 32'h1122_3344;
        axi_write(BASE + 32'h40, 4'h1, 8'd0, 4'hF, 1'b0, 1'b0, resp, bidv);
        check_value("t2_bresp_full", 32'(resp), 0);
        wbuf[0] = 32'hAABB_CCDD;
        axi_write(BASE + 32'h40, 4'h2, 8'd0, 4'b0101, 1'b0, 1'b0, resp, bidv);
        check_value("t2_bresp_strb", 32'(resp), 0);
        axi_read(BASE + 32'h40, 4'h3, 8'd0, 1'b0, "t2", n);
        check_value("t2_data", rbuf[0], 32'h11BB_33DD);
        check_value("t2_rlast", 32'(rlast_buf[0]), 1);

        // Burst straddling the top of the window.
        wbuf[0] = 32'hCAFE_0000;
        wbuf[1] = 32'hCAFE_0001;
        axi_write(EDGE_ADDR, 4'h4, 8'd1, 4'hF, 1'b0, 1'b0, resp, bidv);
        check_value("t3_bresp_edge", 32'(resp), 0);
        axi_read(EDGE_ADDR, 4'h6, 8'd3, 1'b0, "t3", n);
        check_value("t3_data0", rbuf[0], 32'hCAFE_0000);
        check_value("t3_data1", rbuf[1], 32'hCAFE_0001);
        check_value("t3_data2", rbuf[2], 0);
        check_value("t3_data3", rbuf[3], 0);
        check_value("t3_resp0", 32'(rresp_buf[0]), 0);
        check_value("t3_resp1", 32'(rresp_buf[1]), 0);
        check_value("t3_resp2", 32'(rresp_buf[2]), 2);
        check_value("t3_resp3", 32'(rresp_buf[3]), 2);
        check_value("t3_rlast2", 32'(rlast_buf[2]), 0);
        check_value("t3_rlast3", 32'(rlast_buf[3]), 1);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hDEAD_0000 + 32'(i);
        axi_write(EDGE_ADDR, 4'h7, 8'd3, 4'hF, 1'b0, 1'b0, resp, bidv);
        check_value("t3_bresp_oor", 32'(resp), 2);
        axi_read(BASE, 4'h8, 8'd1, 1'b0, "t3_nowrap", n);
        check_value("t3_nowrap0", rbuf[0], 0);
        check_value("t3_nowrap1", rbuf[1], 1);
        axi_read(EDGE_ADDR, 4'h9, 8'd1, 1'b0, "t3_edge", n);
        check_value("t3_edge0", rbuf[0], 32'hDEAD_0000);
        check_value("t3_edge1", rbuf[1], 32'hDEAD_0001);

        // WLAST on the wrong beat, and an address below the base.
        wbuf[0] = 32'h0; wbuf[1] = 32'h0;
        axi_write(BASE + 32'h80, 4'hB, 8'd1, 4'hF, 1'b1, 1'b0, resp, bidv);
        check_value("t4_bresp_wlast", 32'(resp), 2);
        check_value("t4_bid", 32'(bidv), 32'hB);
        axi_read(BASE - 32'h4, 4'hC, 8'd0, 1'b0, "t4_below", n);
        check_value("t4_below_data", rbuf[0], 0);
        check_value("t4_below_resp", 32'(rresp_buf[0]), 2);

        // 256-beat burst with random backpressure on B and R.
        for (int i = 0; i < 256; i++) wbuf[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
        axi_write(BASE + 32'h1000, 4'hD, 8'd255, 4'hF, 1'b0, 1'b1, resp, bidv);
        check_value("t5_bresp", 32'(resp), 0);
        stable_err = 0;
        axi_read(BASE + 32'h1000, 4'hE, 8'd255, 1'b1, "t5", n);
        check_value("t5_stable", 32'(stable_err), 0);
        for (int i = 0; i < 256; i++) begin
            check_value($sformatf("t5_data[%0d]", i), rbuf[i], 32'hA500_0000 ^ (32'(i) * 32'h0001_0101));
        end
        check_value("t5_rlast254", 32'(rlast_buf[254]), 0);
        check_value("t5_rlast255", 32'(rlast_buf[255]), 1);

        // Reset in the middle of a read burst.
        @(negedge clk);
        bus.S_ARVALID = 1'b1; bus.S_ARADDR = BASE; bus.S_ARID = 4'h3; bus.S_ARLEN = 8'd15;
        n = 0;
        while (bus.S_ARREADY !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.S_ARVALID = 1'b0;
        bus.S_RREADY  = 1'b1;
        n = 0;
        for (int t = 0; t < TMO && n < 5; t++) begin
            if (bus.S_RVALID) n++;
            @(negedge clk);
        end
        check_value("t6_beats_before", 32'(n), 5);
        check_value("t6_beat5_data", bus.S_RDATA, 5);
        rst = 1'b1;
        @(negedge clk);
        check_value("t6_rvalid_rst", 32'(bus.S_RVALID), 0);
        check_value("t6_rdata_rst", bus.S_RDATA, 0);
        check_value("t6_arready_rst", 32'(bus.S_ARREADY), 0);
        rst = 1'b0;
        bus.S_RREADY = 1'b0;
        @(negedge clk);
        check_value("t6_arready_rel", 32'(bus.S_ARREADY), 1);
        axi_read(BASE, 4'h4, 8'd15, 1'b0, "t6", n);
        for (int i = 0; i < 16; i++) begin
            check_value($sformatf("t6_data[%0d]", i), rbuf[i], 32'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter AXI_WIDTH_AD, default 32, address width.
REQ-002 SHALL have parameter AXI_WIDTH_ID, default 4, ID width; AXI_WIDTH_DA fixed 32, AXI_WIDTH_DS = 4.
REQ-003 SHALL have parameter MEM_BASE_ADDR, default 'h8000_0000, byte base of window; MEM_DEPTH, default 65536, words; MEM_AW = $clog2(MEM_DEPTH).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port S_AWVALID  input  1  write address valid.
REQ-007 SHALL have port S_AWREADY  output  1  write address accepted.
REQ-008 SHALL have port S_AWADDR  input  AXI_WIDTH_AD  burst start byte address.
REQ-009 SHALL have port S_AWID  input  AXI_WIDTH_ID  write burst ID.
REQ-010 SHALL have port S_AWLEN  input  8  beats minus one.
REQ-011 SHALL have port S_WVALID  input  1  write data valid.
REQ-012 SHALL have port S_WREADY  output  1  write data accepted.
REQ-013 SHALL have port S_WDATA  input  32  write data.
REQ-014 SHALL have port S_WSTRB  input  4  byte lane enables.
REQ-015 SHALL have port S_WLAST  input  1  last write beat.
REQ-016 SHALL have port S_BVALID  output  1  write response valid.
REQ-017 SHALL have port S_BREADY  input  1  write response accepted.
REQ-018 SHALL have port S_BRESP  output  2  OKAY 2'b00 / SLVERR 2'b10.
REQ-019 SHALL have port S_BID  output  AXI_WIDTH_ID  echo of AWID.
REQ-020 SHALL have port S_ARVALID  input  1  read address valid.
REQ-021 SHALL have port S_ARREADY  output  1  read address accepted.
REQ-022 SHALL have port S_ARADDR  input  AXI_WIDTH_AD  burst start byte address.
REQ-023 SHALL have port S_ARID  input  AXI_WIDTH_ID  read burst ID.
REQ-024 SHALL have port S_ARLEN  input  8  beats minus one.
REQ-025 SHALL have port S_RVALID  output  1  read data valid.
REQ-026 SHALL have port S_RREADY  input  1  read data accepted.
REQ-027 SHALL have port S_RDATA  output  32  read data.
REQ-028 SHALL have port S_RLAST  output  1  last read beat.
REQ-029 SHALL have port S_RID / S_RRESP  output  AXI_WIDTH_ID / 2  echo of ARID / per-beat response.

Function
REQ-030 SHALL serve INCR bursts of 4-byte beats from an internal MEM_DEPTH x 32 array; beat n word index = ((addr - MEM_BASE_ADDR) >> 2) + n.
REQ-031 Write FSM SHALL be W_IDLE (AWREADY=1) -> W_DATA on AW handshake (capture ID, LEN, index; AWREADY=0, WREADY=1) -> W_RESP after beat LEN+1 (WREADY=0, BVALID=1) -> W_IDLE on BVALID&BREADY; one outstanding write.
REQ-032 Each accepted W beat SHALL update only bytes with WSTRB set, in the handshake cycle.
REQ-033 BRESP SHALL be SLVERR if any beat index is out of range (>= MEM_DEPTH, or addr < base) or WLAST disagrees with beat count; out-of-range beats SHALL be dropped; otherwise OKAY.
REQ-034 Read FSM SHALL be R_IDLE (ARREADY=1) -> R_DATA on AR handshake (ARREADY=0); first RVALID exactly 1 cycle after AR handshake; each RVALID&RREADY advances one beat with next data valid the following cycle (full throughput under RREADY=1); RLAST on beat LEN+1; R_IDLE after last handshake; one outstanding read.
REQ-035 RDATA, RID, RRESP, RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-036 Out-of-range read beats SHALL return RDATA=0, RRESP=SLVERR; in-range beats OKAY.
REQ-037 Read and write FSMs SHALL run concurrently; same-word read and write in one cycle SHALL return the old data (read-first).
REQ-038 Beat counters SHALL be 8 bits; LEN=0 and LEN=255 SHALL both be supported; index arithmetic SHALL be done in AXI_WIDTH_AD bits before range check (no wrap into the array).

Reset
REQ-039 On rst=1 next edge: AWREADY=ARREADY=0, WREADY=BVALID=RVALID=RLAST=0, BRESP=RRESP=0, BID=RID=0, RDATA=0, FSMs to idle, any in-flight burst abandoned; memory contents SHALL NOT be cleared; AWREADY/ARREADY rise the first cycle after rst=0.

Structure
REQ-040 Response codes, FSM state encodings and MEM_BASE_ADDR default SHALL live in a shared package/define file with the DMA blocks.
REQ-041 Storage SHALL be one sub-module axi_mem_slave_ram (1 write port with byte enables, 1 registered read port, no reset).

Verification
REQ-042 Write AWADDR=base, AWLEN=15, data 0..15, WSTRB=4'hF -> BRESP=OKAY, BID=AWID; read same -> 16 beats 0..15, RLAST only on 16th, RVALID 1 cycle after AR.
REQ-043 Write word 0x11223344 then WSTRB=4'b0101 data 0xAABBCCDD -> read returns 0x11BB33DD.
REQ-044 Read AWLEN=3 at base+(MEM_DEPTH-2)*4 -> beats 0,1 OKAY with data, beats 2,3 RDATA=0 RRESP=SLVERR.
REQ-045 Random RREADY/BREADY backpressure (50%) on 256-beat burst -> RDATA stable while stalled, all 256 beats in order.
REQ-046 Assert rst mid read burst (beat 5 of 16) -> RVALID=0 next cycle, ARREADY=1 after release, memory data intact on reread.
